// File: rtl/mcu_fpga_bus_arbiter.sv
// mcu_fpga_bus_arbiter: round-robin arbiter + SETUP/ACCESS/RELEASE sequencer
// sharing the MCU-side master port of mcu_fpga_bus between NREQ requesters.
// Optional feature macro: MCU_BUS_TIMEOUT_EN (abort stalled ACCESS/RELEASE
// after TIMEOUT cycles and flag err). Without it the FSM waits indefinitely.
module mcu_fpga_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     CLK50,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic                     write_enable,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata,
  output logic                     mcu_mstr,
  input  logic                     fpga_ack
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("mcu_fpga_bus_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;       // index where the next search starts
  logic [IDX_W-1:0]    idx_q, idx_d;     // requester currently owning the bus
  logic                lwe_q, lwe_d;     // latched direction of the granted access
  logic [NREQ-1:0]     done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mstr_q, mstr_d;

  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;

`ifdef MCU_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cnt_hit;
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign write_enable = we_q;
  assign address      = addr_q;
  assign bus_wdata    = wdata_q;
  assign mcu_mstr     = mstr_q;

  // Round-robin search: first set req bit at or after rr_q, wrapping.
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    lwe_d   = lwe_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mstr_d  = mstr_q;
`ifdef MCU_BUS_TIMEOUT_EN
    cnt_d   = '0;           // cleared on every state change
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = SETUP;
          idx_d   = gnt_idx;
          lwe_d   = req_we[gnt_idx];
          we_d    = req_we[gnt_idx];
          addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[gnt_idx*DATA_W +: DATA_W];
          mstr_d  = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        mstr_d  = 1'b1;
      end
      ACCESS: begin
        if (fpga_ack) begin
          if (!lwe_q) rdata_d = bus_rdata;
          done_d[idx_q] = 1'b1;
          state_d = RELEASE;
          mstr_d  = 1'b0;
          we_d    = 1'b0;
        end
`ifdef MCU_BUS_TIMEOUT_EN
        else if (cnt_hit) begin
          // Abort: complete with err, rdata left untouched.
          done_d[idx_q] = 1'b1;
          err_d   = 1'b1;
          state_d = RELEASE;
          mstr_d  = 1'b0;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        // Waiting for ack to drop keeps a sticky ack from being counted twice.
        if (!fpga_ack) begin
          state_d = IDLE;
          rr_d    = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
        end
`ifdef MCU_BUS_TIMEOUT_EN
        else if (cnt_hit) begin
          state_d = IDLE;
          rr_d    = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; async reset clears everything at once.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      lwe_q   <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mstr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      lwe_q   <= lwe_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mstr_q  <= mstr_d;
    end
  end

`ifdef MCU_BUS_TIMEOUT_EN
  // Stall counter for ACCESS/RELEASE.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule
